// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Drives an external 64-bit ALU to run single-pass and repeated
//            shift operations, capturing operand compare flags on the way.
// Revision : 1.0
// ============================================================================
module alu_sequencer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [CNT_W-1:0] in_cnt,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [63:0]      alu_out,
    input  logic             alu_gt,
    input  logic             alu_lt,
    input  logic             alu_eq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [63:0]        acc_q, acc_d;
    logic [63:0]        b_q, b_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               first_q, first_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            acc_q   <= 64'd0;
            b_q     <= 64'd0;
            rem_q   <= '0;
            first_q <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        b_d     = b_q;
        rem_d   = rem_q;
        first_d = first_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EXEC;
                    op_d    = in_op;
                    acc_d   = in_a;
                    b_d     = in_b;
                    rem_d   = in_cnt;
                    first_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_EXEC: begin
                first_d = 1'b0;
                // acc still holds the original operand only on the first pass
                if (first_q) begin
                    gt_d = alu_gt;
                    lt_d = alu_lt;
                    eq_d = alu_eq;
                end
                if (!op_q[2]) begin
                    acc_d   = alu_out;
                    state_d = S_DONE;
                end else if (op_q[1]) begin
                    acc_d   = 64'd0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    acc_d = alu_out;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = acc_q;
    assign out_gt     = gt_q;
    assign out_lt     = lt_q;
    assign out_eq     = eq_q;
    assign out_err    = err_q;
    assign alu_a      = acc_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with a behavioural ALU and
//            an operation-level reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [63:0]   in_a;
    logic [63:0]   in_b;
    logic [CW-1:0] in_cnt;
    logic [63:0]   alu_a;
    logic [63:0]   alu_b;
    logic [2:0]    alu_ctrl;
    logic [63:0]   alu_out;
    logic          alu_gt;
    logic          alu_lt;
    logic          alu_eq;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_result;
    logic          out_gt;
    logic          out_lt;
    logic          out_eq;
    logic          out_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cnt     (in_cnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_gt     (alu_gt),
        .alu_lt     (alu_lt),
        .alu_eq     (alu_eq),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_gt     (out_gt),
        .out_lt     (out_lt),
        .out_eq     (out_eq),
        .out_err    (out_err),
        .busy       (busy)
    );

    // External ALU; unsupported codes return junk the sequencer must discard
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a << 1;
            3'b101:  alu_out = alu_a >> 1;
            default: alu_out = 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    end
    assign alu_gt = (alu_a > alu_b);
    assign alu_lt = (alu_a < alu_b);
    assign alu_eq = (alu_a == alu_b);

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [CW-1:0] cnt);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a << cnt;
            3'd5:    return a >> cnt;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request from an idle DUT, checks the result, holds it for
    // `hold` cycles, then hands it off and checks the return to idle.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [CW-1:0] cnt, input int hold);
        logic [63:0] er;
        int          el;
        int          n;
        logic        bad_ready;
        logic        stable;
        er = ref_res(op, a, b, cnt);
        el = ((op == 3'd4 || op == 3'd5) && cnt != '0) ? 1 + int'(cnt) : 2;
        chk("ready_before", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cnt = cnt;
        @(posedge clk); #1;
        n = 1;
        bad_ready = 1'b0;
        while (!out_valid && n < 300) begin
            if (in_ready) bad_ready = 1'b1;
            in_op  = 3'($urandom);
            in_a   = {$urandom, $urandom};
            in_b   = {$urandom, $urandom};
            in_cnt = CW'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'(el));
        chk("ready_while_exec", 64'(bad_ready), 64'd0);
        chk("result", out_result, er);
        chk("gt", 64'(out_gt), 64'(a > b));
        chk("lt", 64'(out_lt), 64'(a < b));
        chk("eq", 64'(out_eq), 64'(a == b));
        chk("err", 64'(out_err), 64'(op >= 3'd6));
        chk("busy_done", 64'(busy), 64'd1);
        chk("ready_done", 64'(in_ready), 64'd0);
        chk("alu_b", alu_b, b);
        chk("alu_ctrl", 64'(alu_ctrl), 64'(op));
        stable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_result !== er || in_ready) stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_after_handoff", 64'(out_valid), 64'd0);
        chk("ready_after_handoff", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [2:0]    rop;
        logic [63:0]   ra;
        logic [63:0]   rb;
        logic [CW-1:0] rc;
        logic          seen;

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 64'd0; in_b = 64'd0;
        in_cnt = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_flags", 64'({out_gt, out_lt, out_eq, out_err}), 64'd0);
        chk("rst_alu", alu_a | alu_b | 64'(alu_ctrl), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 64'd5, 64'd3, 6'd0, 0);
        run_op(3'd1, 64'd0, 64'd1, 6'd0, 1);
        run_op(3'd4, 64'd1, 64'd1, 6'd5, 0);
        run_op(3'd4, 64'd1, 64'd1, 6'd0, 0);
        run_op(3'd5, 64'h8000_0000_0000_0000, 64'd7, 6'd63, 0);
        run_op(3'd5, 64'd1, 64'd1, 6'd63, 0);
        run_op(3'd7, 64'd9, 64'd2, 6'd3, 0);
        run_op(3'd0, 64'd2, 64'd9, 6'd0, 0);
        run_op(3'd6, 64'd4, 64'd4, 6'd0, 0);
        run_op(3'd2, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 6'd0, 4);
        run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 0);
        run_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd0, 0);

        // abort an in-flight shift; its result must never appear
        in_valid = 1'b1; in_op = 3'd4; in_a = 64'h3; in_b = 64'h1; in_cnt = 6'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_result", out_result, 64'd0);
        chk("abort_flags", 64'({out_gt, out_lt, out_eq, out_err}), 64'd0);
        chk("abort_alu", alu_a | alu_b | 64'(alu_ctrl), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);

        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom);
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
            rc  = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
            run_op(rop, ra, rb, rc, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
